// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
// Contents: FSM state codes, opcode/funct constants, ALU_Control and
// ALU_SrcB encodings, the packed control-word struct and an opcode helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BEQ      = 4'd9,
        S_BNE      = 4'd10,
        S_JMP      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       mem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       branch;
        logic       branch_ne;
        logic       alu_srca;
        logic       reg_write;
        logic       mem_reg;
        logic       reg_dst;
        logic       pc_j;
        logic       zero_ext;
        logic [2:0] alu_control;
        logic [1:0] alu_srcb;
    } ctrl_t;

    // I-type ALU instructions share the EX_I / ALU_WB path.
    function automatic logic is_alu_i_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decode.sv
// rtl/mc_control_unit_alu_decode.sv - Op/Funct to ALU operation decode
// Module mc_alu_decode (combinational)
//   op, funct   : instruction fields from the instruction register
//   alu_control : ALU operation for EX_R / EX_I / ALU_WB (ALU_PASS when undecodable)
//   zero_ext    : zero-extend the immediate (ANDI/ORI)
//   reg_dst     : destination register comes from rd (R-type)
//   legal       : op/funct pair names a supported ALU instruction
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       zero_ext,
    output logic       reg_dst,
    output logic       legal
);

    always_comb begin
        alu_control = ALU_PASS;
        zero_ext    = 1'b0;
        reg_dst     = 1'b0;
        legal       = 1'b0;
        case (op)
            OP_R: begin
                // rd is the destination for every R-type, legal or not.
                reg_dst = 1'b1;
                legal   = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: legal       = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_control = ALU_ADD;
                legal       = 1'b1;
            end
            OP_ANDI: begin
                alu_control = ALU_AND;
                zero_ext    = 1'b1;
                legal       = 1'b1;
            end
            OP_ORI: begin
                alu_control = ALU_OR;
                zero_ext    = 1'b1;
                legal       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS control FSM (Moore, with memory handshake)
// Parameters: MEM_WAIT_EN (1 = honour Mem_Ready), STATE_W (State output width)
// Inputs : clk, rst (async active-low), Op, Funct, Mem_Ready
// Outputs: datapath controls IorD .. Zero_Ext, ALU_Control[2:0], ALU_SrcB[1:0],
//          sticky Illegal, debug State[STATE_W-1:0]
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Mem_Ready,
    output logic               IorD,
    output logic               Mem_Write,
    output logic               Mem_Req,
    output logic               IR_Write,
    output logic               PC_Write,
    output logic               PC_Src,
    output logic               Branch,
    output logic               Branch_Ne,
    output logic               ALU_SrcA,
    output logic               Reg_Write,
    output logic               Mem_Reg,
    output logic               Reg_Dst,
    output logic               PC_J,
    output logic               Zero_Ext,
    output logic [2:0]         ALU_Control,
    output logic [1:0]         ALU_SrcB,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       ready;
    ctrl_t      ctrl;

    logic [2:0] dec_alu_control;
    logic       dec_zero_ext;
    logic       dec_reg_dst;
    logic       dec_legal;

    mc_alu_decode u_alu_decode (
        .op          (Op),
        .funct       (Funct),
        .alu_control (dec_alu_control),
        .zero_ext    (dec_zero_ext),
        .reg_dst     (dec_reg_dst),
        .legal       (dec_legal)
    );

    // With waiting disabled every memory access completes in its first cycle.
    assign ready = Mem_Ready | ~MEM_WAIT_EN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (ready) state_d = S_ID;
            end
            S_ID: begin
                if (Op == OP_R)                       state_d = S_EX_R;
                else if (is_alu_i_op(Op))             state_d = S_EX_I;
                else if (Op == OP_LW || Op == OP_SW)  state_d = S_MEM_ADDR;
                else if (Op == OP_BEQ)                state_d = S_BEQ;
                else if (Op == OP_BNE)                state_d = S_BNE;
                else if (Op == OP_J)                  state_d = S_JMP;
                else                                  state_d = S_TRAP;
            end
            // Unknown Funct is only discoverable here, so the trap is taken
            // one state later than for an unknown opcode.
            S_EX_R:     state_d = dec_legal ? S_ALU_WB : S_TRAP;
            S_EX_I:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_IF;
            S_MEM_ADDR: begin
                if (Op == OP_LW)      state_d = S_MEM_RD;
                else if (Op == OP_SW) state_d = S_MEM_WR;
                else                  state_d = S_TRAP;
            end
            S_MEM_RD: begin
                if (ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (ready) state_d = S_IF;
            end
            S_MEM_WB:   state_d = S_IF;
            S_BEQ:      state_d = S_IF;
            S_BNE:      state_d = S_IF;
            S_JMP:      state_d = S_IF;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IF;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_IF: begin
                ctrl.mem_req     = 1'b1;
                ctrl.alu_srcb    = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_j        = 1'b1;
                // Strobes only in the cycle the fetch completes.
                ctrl.ir_write    = ready;
                ctrl.pc_write    = ready;
            end
            S_ID: begin
                ctrl.alu_srcb    = SRCB_IMM_SH;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_j        = 1'b1;
            end
            S_EX_R: begin
                ctrl.alu_srca    = 1'b1;
                ctrl.alu_srcb    = SRCB_REG;
                ctrl.alu_control = dec_alu_control;
                ctrl.zero_ext    = dec_zero_ext;
                ctrl.reg_dst     = dec_reg_dst;
            end
            S_EX_I: begin
                ctrl.alu_srca    = 1'b1;
                ctrl.alu_srcb    = SRCB_IMM;
                ctrl.alu_control = dec_alu_control;
                ctrl.zero_ext    = dec_zero_ext;
                ctrl.reg_dst     = dec_reg_dst;
            end
            S_ALU_WB: begin
                // Re-decoded from the held IR so the result path stays stable.
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = dec_alu_control;
                ctrl.zero_ext    = dec_zero_ext;
                ctrl.reg_dst     = dec_reg_dst;
            end
            S_MEM_ADDR: begin
                ctrl.alu_srca    = 1'b1;
                ctrl.alu_srcb    = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord        = 1'b1;
                ctrl.mem_req     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord        = 1'b1;
                ctrl.mem_req     = 1'b1;
                ctrl.mem_write   = ready;
            end
            S_MEM_WB: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_reg     = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_srca    = 1'b1;
                ctrl.alu_srcb    = SRCB_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_src      = 1'b1;
                ctrl.pc_j        = 1'b1;
                ctrl.branch      = 1'b1;
                ctrl.branch_ne   = (state_q == S_BNE);
            end
            S_JMP: begin
                ctrl.pc_write    = 1'b1;
                ctrl.pc_src      = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables and the memory request are gated by rst directly so that
    // they fall with reset itself, independent of the state register.
    assign IorD        = ctrl.iord;
    assign Mem_Write   = ctrl.mem_write & rst;
    assign Mem_Req     = ctrl.mem_req   & rst;
    assign IR_Write    = ctrl.ir_write  & rst;
    assign PC_Write    = ctrl.pc_write  & rst;
    assign Reg_Write   = ctrl.reg_write & rst;
    assign PC_Src      = ctrl.pc_src;
    assign Branch      = ctrl.branch;
    assign Branch_Ne   = ctrl.branch_ne;
    assign ALU_SrcA    = ctrl.alu_srca;
    assign Mem_Reg     = ctrl.mem_reg;
    assign Reg_Dst     = ctrl.reg_dst;
    assign PC_J        = ctrl.pc_j;
    assign Zero_Ext    = ctrl.zero_ext;
    assign ALU_Control = ctrl.alu_control;
    assign ALU_SrcB    = ctrl.alu_srcb;
    assign Illegal     = illegal_q;
    assign State       = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit
module tb_mc_control_unit;

    localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX_R = 4'd2, ST_EX_I = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WR = 4'd6;
    localparam logic [3:0] ST_MEM_WB = 4'd7, ST_ALU_WB = 4'd8, ST_BEQ = 4'd9;
    localparam logic [3:0] ST_BNE = 4'd10, ST_JMP = 4'd11, ST_TRAP = 4'd12;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Mem_Ready;
    logic       IorD, Mem_Write, Mem_Req, IR_Write, PC_Write, PC_Src, Branch, Branch_Ne;
    logic       ALU_SrcA, Reg_Write, Mem_Reg, Reg_Dst, PC_J, Zero_Ext, Illegal;
    logic [2:0] ALU_Control;
    logic [1:0] ALU_SrcB;
    logic [3:0] State;

    int n_checks = 0;
    int n_pass   = 0;

    mc_control_unit #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Mem_Ready(Mem_Ready),
        .IorD(IorD), .Mem_Write(Mem_Write), .Mem_Req(Mem_Req), .IR_Write(IR_Write),
        .PC_Write(PC_Write), .PC_Src(PC_Src), .Branch(Branch), .Branch_Ne(Branch_Ne),
        .ALU_SrcA(ALU_SrcA), .Reg_Write(Reg_Write), .Mem_Reg(Mem_Reg), .Reg_Dst(Reg_Dst),
        .PC_J(PC_J), .Zero_Ext(Zero_Ext), .ALU_Control(ALU_Control), .ALU_SrcB(ALU_SrcB),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One expected step of an instruction: state, whether memory completes,
    // and whether Mem_Ready is meaningful there.
    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       mem;
    } step_t;

    step_t path[$];

    function automatic logic [2:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20: return 3'b001;
                6'h22: return 3'b100;
                6'h24: return 3'b010;
                6'h25: return 3'b011;
                6'h2A: return 3'b101;
                default: return 3'b000;
            endcase
        end
        case (op)
            6'h08, 6'h09: return 3'b001;
            6'h0C: return 3'b010;
            6'h0D: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic r_legal(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    // Expected control word, built field by field from which states assert it.
    function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic [5:0] op, input logic [5:0] fn);
        logic iord, mw, mr, irw, pcw, pcs, br, bne, sa, rw, mreg, rd, pcj, ze, ill;
        logic [2:0] alu;
        logic [1:0] sb;
        iord = st inside {ST_MEM_RD, ST_MEM_WR};
        mw   = (st == ST_MEM_WR) && rdy;
        mr   = st inside {ST_IF, ST_MEM_RD, ST_MEM_WR};
        irw  = (st == ST_IF) && rdy;
        pcw  = ((st == ST_IF) && rdy) || (st == ST_JMP);
        pcs  = st inside {ST_BEQ, ST_BNE, ST_JMP};
        br   = st inside {ST_BEQ, ST_BNE};
        bne  = (st == ST_BNE);
        sa   = st inside {ST_EX_R, ST_EX_I, ST_MEM_ADDR, ST_BEQ, ST_BNE};
        rw   = st inside {ST_ALU_WB, ST_MEM_WB};
        mreg = (st == ST_MEM_WB);
        rd   = (st inside {ST_EX_R, ST_ALU_WB}) && (op == 6'h00);
        pcj  = st inside {ST_IF, ST_ID, ST_BEQ, ST_BNE};
        ze   = (st inside {ST_EX_I, ST_ALU_WB}) && (op inside {6'h0C, 6'h0D});
        ill  = (st == ST_TRAP);
        if (st inside {ST_IF, ST_ID, ST_MEM_ADDR}) alu = 3'b001;
        else if (st inside {ST_BEQ, ST_BNE})       alu = 3'b100;
        else if (st inside {ST_EX_R, ST_EX_I, ST_ALU_WB}) alu = ref_alu(op, fn);
        else                                       alu = 3'b000;
        if (st == ST_IF)                           sb = 2'b01;
        else if (st == ST_ID)                      sb = 2'b11;
        else if (st inside {ST_EX_I, ST_MEM_ADDR}) sb = 2'b10;
        else                                       sb = 2'b00;
        return {iord, mw, mr, irw, pcw, pcs, br, bne, sa, rw, mreg, rd, pcj, ze, alu, sb, ill};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {IorD, Mem_Write, Mem_Req, IR_Write, PC_Write, PC_Src, Branch, Branch_Ne,
                ALU_SrcA, Reg_Write, Mem_Reg, Reg_Dst, PC_J, Zero_Ext, ALU_Control, ALU_SrcB, Illegal};
    endfunction

    task automatic add_steps(input logic [3:0] st, input int waits, input logic mem);
        for (int i = 0; i <= waits; i++) path.push_back('{st: st, rdy: (i == waits), mem: mem});
    endtask

    // Builds the instruction's state path from the instruction class, then
    // drives and checks it one cycle at a time. Entered and left at a negedge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int w_if,
                             input int w_mem, input int max_steps, output logic trapped);
        path.delete();
        add_steps(ST_IF, w_if, 1'b1);
        add_steps(ST_ID, 0, 1'b0);
        case (op)
            6'h00: begin
                add_steps(ST_EX_R, 0, 1'b0);
                add_steps(r_legal(fn) ? ST_ALU_WB : ST_TRAP, 0, 1'b0);
            end
            6'h08, 6'h09, 6'h0C, 6'h0D: begin
                add_steps(ST_EX_I, 0, 1'b0);
                add_steps(ST_ALU_WB, 0, 1'b0);
            end
            6'h23: begin
                add_steps(ST_MEM_ADDR, 0, 1'b0);
                add_steps(ST_MEM_RD, w_mem, 1'b1);
                add_steps(ST_MEM_WB, 0, 1'b0);
            end
            6'h2B: begin
                add_steps(ST_MEM_ADDR, 0, 1'b0);
                add_steps(ST_MEM_WR, w_mem, 1'b1);
            end
            6'h04: add_steps(ST_BEQ, 0, 1'b0);
            6'h05: add_steps(ST_BNE, 0, 1'b0);
            6'h02: add_steps(ST_JMP, 0, 1'b0);
            default: add_steps(ST_TRAP, 0, 1'b0);
        endcase
        trapped = (path[path.size()-1].st == ST_TRAP);
        if (trapped) add_steps(ST_TRAP, 1, 1'b0);
        Op = op;
        Funct = fn;
        for (int k = 0; k < path.size() && k < max_steps; k++) begin
            Mem_Ready = path[k].mem ? path[k].rdy : 1'($urandom_range(0, 1));
            #1;
            check($sformatf("state op%h fn%h step%0d", op, fn, k), 32'(State), 32'(path[k].st));
            check($sformatf("ctrl op%h fn%h st%0d", op, fn, path[k].st), 32'(obs_vec()),
                  32'(exp_vec(path[k].st, Mem_Ready, op, fn)));
            @(negedge clk);
        end
    endtask

    // Asynchronous reset a little after a negedge, checked before the next
    // rising edge, released on the following negedge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        check({tag, " state"}, 32'(State), 32'(ST_IF));
        check({tag, " illegal"}, 32'(Illegal), 32'd0);
        check({tag, " mem_req"}, 32'(Mem_Req), 32'd0);
        check({tag, " mem_write"}, 32'(Mem_Write), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic trapped;
        logic [5:0] op, fn;
        rst = 1'b0;
        Op = 6'h00;
        Funct = 6'h20;
        Mem_Ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset state", 32'(State), 32'(ST_IF));
        check("reset illegal", 32'(Illegal), 32'd0);
        check("reset write enables", 32'({Mem_Req, IR_Write, PC_Write, Reg_Write, Mem_Write}), 32'd0);
        check("reset if values", 32'({PC_J, ALU_SrcB, ALU_Control, IorD, ALU_SrcA}), 32'({1'b1, 2'b01, 3'b001, 2'b00}));
        rst = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, 1000, trapped);
        run_instr(6'h23, 6'h00, 0, 2, 1000, trapped);
        run_instr(6'h2B, 6'h11, 1, 1, 1000, trapped);
        run_instr(6'h05, 6'h00, 0, 0, 1000, trapped);
        run_instr(6'h3F, 6'h00, 0, 0, 1000, trapped);
        async_reset("trap op reset");
        run_instr(6'h00, 6'h03, 0, 0, 1000, trapped);
        async_reset("trap funct reset");

        // SW held in a MEM_WR wait, then reset with the write strobe live.
        run_instr(6'h2B, 6'h00, 0, 5, 4, trapped);
        Mem_Ready = 1'b1;
        #1;
        check("memwr wait state", 32'(State), 32'(ST_MEM_WR));
        check("memwr strobe live", 32'({Mem_Req, Mem_Write, IorD}), 32'(3'b111));
        #1;
        rst = 1'b0;
        #1;
        check("memwr reset state", 32'(State), 32'(ST_IF));
        check("memwr reset strobes", 32'({Mem_Req, Mem_Write, IorD}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        Mem_Ready = 1'b0;

        for (int n = 0; n < 80; n++) begin
            op = op_tab[$urandom_range(0, 11)];
            if (op == 6'h3F) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 4)];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1000, trapped);
            if (trapped) async_reset("random trap reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
